spi_master: RTL and testbench
=============================

# spi_master

SPI mode-0 master that drives the `sck`/`ss`/`mosi` pins of an SPI peripheral and captures its `miso` line. It sits between a bus-side request/response port and the SPI pins, directly upstream of SPI slaves such as the bit-reversal test peripheral. It performs one transfer per request, MSB first, of 1..MAX_LEN bits. The transfer length and clock divider are chosen per request.

## Interface
- `MAX_LEN`, 32: maximum bits per transfer. Width of the data fields.
- `LW`, $clog2(MAX_LEN): width of `req_len_m1`.
- `DW`, 8: width of `req_div`.
- `clock` input 1: single clock. All logic is on its rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: a request is present.
- `req_ready` output 1: high exactly when in IDLE. Reset value 1, in the cycle after reset deasserts.
- `req_wdata` input MAX_LEN: transmit data, right-aligned. The first bit sent is `req_wdata[len-1]`.
- `req_len_m1` input LW: transfer length minus one (len = value+1).
- `req_div` input DW: SCK half-period is H = req_div+1 clock cycles.
- `resp_valid` output 1: `resp_rdata` is valid. Held until accepted. Reset value 0.
- `resp_ready` input 1: response is accepted.
- `resp_rdata` output MAX_LEN: received bits, right-aligned. Bits at and above len are 0. Reset value 0.
- `sck` output 1: SPI clock, idle low. Reset value 0.
- `ss` output 1: slave select, active low. Reset value 1.
- `mosi` output 1: master out. Idles at 1. Reset value 1.
- `miso` input 1: slave out. Treated as synchronous to `clock` in this design.

## Operation
- States: IDLE, LOW, HIGH, TRAIL, RESP.
- IDLE:
  - On `req_valid`: latch wdata, len, and H. Drive `ss`<=0 and `mosi`<=wdata[len-1]. Load the half-period counter with H-1, set bit count to len. Go to LOW.
- LOW (`sck`=0):
  - When the counter reaches 0: `sck`<=1, reload the counter, go to HIGH.
- HIGH (`sck`=1):
  - When the counter reaches 0: `sck`<=0. Shift the current `miso` value into the rx shift register LSB and decrement the bit count.
  - If that was the last bit, go to TRAIL.
  - Otherwise `mosi`<=next lower bit, reload the counter, go to LOW.
- TRAIL (`sck`=0, `ss`=0):
  - After H cycles: `ss`<=1, `mosi`<=1, `resp_rdata`<=rx register, `resp_valid`<=1. Go to RESP.
- RESP:
  - When `resp_valid && resp_ready`: `resp_valid`<=0, go to IDLE.
  - No new request is accepted before the response is consumed.
- Capture rule: `miso` is sampled in the same clock edge that drives `sck` low. `mosi` updates on that same edge, so the captured value precedes the new `mosi` bit. A loopback (`miso`=`mosi`) therefore returns `req_wdata` exactly.
- Slave compatibility: a slave that samples `mosi` and updates `miso` on the rising SCK edge sees `mosi` stable for H cycles before each rising edge. Its `miso` is stable H cycles before capture.
- Counter width is DW. H-1 = req_div, so there is no overflow at req_div = 2^DW-1. req_div=0 gives H=1 and SCK = clock/2.
- `req_len_m1`=MAX_LEN-1 transfers the full word. The rx shift register is cleared on accept.

## Timing
- Accept on edge T0. `ss` falls and the first `mosi` bit is valid from T0+1.
- Rising SCK edge k (k = 1..len) is at T0 + (2k-1)·H. Falling SCK edge / capture k is at T0 + 2k·H.
- `ss` rises and `resp_valid` asserts at T0 + (2·len+1)·H.
- `req_ready` is 0 from T0+1 until the cycle after the response handshake.
- Reset in any state, including mid-transfer: next cycle has IDLE, `ss`=1, `sck`=0, `mosi`=1, `resp_valid`=0, `resp_rdata`=0. The partial transfer is discarded.
- `req_valid` while not in IDLE is ignored. No request is buffered.
- `resp_ready` while `resp_valid`=0 has no effect.

## Structure
- Package `spi_pkg`: the state enum (IDLE, LOW, HIGH, TRAIL, RESP), the SPI idle levels (SCK_IDLE=0, SS_IDLE=1, MOSI_IDLE=1), and the default MAX_LEN.
- One sub-module, `spi_halfper_cnt`: a loadable down-counter of width DW with a `zero` output. It is used for every LOW, HIGH and TRAIL phase.
- The FSM, tx/rx shift registers and bit counter live in `spi_master`.

## Test plan
- Loopback, `miso`=`mosi`, len_m1=31, div=0, wdata=0xDEADBEEF:
  - rdata=0xDEADBEEF.
  - `resp_valid` at T0+65.
  - 32 rising SCK edges.
- Bit-reversal slave attached, len_m1=15, div=3, wdata=0x0000A500:
  - rdata=0x0000FFA5.
  - `ss` low for 132 cycles.
- `miso` tied to 0, len_m1=0, div=0, wdata=1:
  - One SCK pulse, `mosi`=1 during it, rdata=0.
  - `resp_valid` at T0+3.
- Backpressure: hold `resp_ready`=0 for 10 cycles and pulse `req_valid` meanwhile:
  - `resp_valid` and rdata stay stable and `req_ready`=0.
  - The request is not taken and no SCK toggles occur.
- Reset asserted mid-transfer, after 5 falling SCK edges of a 16-bit transfer:
  - Next cycle `ss`=1, `sck`=0, `mosi`=1, `req_ready`=1, `resp_valid`=0.
  - A following loopback transfer of 0x1234 returns 0x1234.
- Divider extreme, div=255, len_m1=1, loopback, wdata=0x2:
  - Each SCK half-period is 256 cycles, rdata=0x2.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 master.
//   - FSM state codes (IDLE, LOW, HIGH, TRAIL, RESP)
//   - idle levels of the SPI pins
//   - default transfer width
package spi_pkg;
  localparam int MAX_LEN_DEF = 32;

  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t LOW   = 3'd1;
  localparam state_t HIGH  = 3'd2;
  localparam state_t TRAIL = 3'd3;
  localparam state_t RESP  = 3'd4;

  localparam logic SCK_IDLE  = 1'b0;
  localparam logic SS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b1;
endpackage

// File: rtl/spi_halfper_cnt.sv
// Loadable down-counter timing every SCK half-period and the trailing phase.
//   clock, reset : clock, synchronous active-high reset
//   load         : load load_val this cycle (takes priority over counting)
//   load_val     : value to load (H-1)
//   zero         : counter is at zero
// The counter holds at zero rather than wrapping.
module spi_halfper_cnt #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  output logic          zero
);
  logic [DW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)          cnt <= '0;
    else if (load)      cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, 1..MAX_LEN bits per request.
//   clock, reset            : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_wdata, req_len_m1   : right-aligned tx data, length-1
//   req_div                 : SCK half-period = req_div+1 clocks
//   resp_valid/resp_ready   : response handshake, rdata held until taken
//   resp_rdata              : right-aligned rx data, upper bits zero
//   sck, ss, mosi, miso     : SPI pins (miso synchronous to clock)
module spi_master
  import spi_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LW      = $clog2(MAX_LEN),
  parameter int DW      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [MAX_LEN-1:0] req_wdata,
  input  logic [LW-1:0]      req_len_m1,
  input  logic [DW-1:0]      req_div,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [MAX_LEN-1:0] resp_rdata,
  output logic               sck,
  output logic               ss,
  output logic               mosi,
  input  logic               miso
);
  localparam logic [LW:0]   ONE    = (LW+1)'(1);
  localparam logic [LW-1:0] SH_MAX = LW'(MAX_LEN-1);

  state_t             state;
  logic [MAX_LEN-1:0] tx_sh, rx_sh, tx_aligned;
  logic [LW:0]        bcnt;
  logic [DW-1:0]      div_q;
  logic               zero, cnt_load;
  logic [DW-1:0]      cnt_val;

  // Left-align the tx word so the next bit out is always the MSB.
  assign tx_aligned = req_wdata << (SH_MAX - req_len_m1);
  assign req_ready  = (state == IDLE);

  // Reload on accept and at every SCK edge; the reload at the last falling
  // edge times the trailing ss-low phase.
  assign cnt_load = (state == IDLE && req_valid) ||
                    ((state == LOW || state == HIGH) && zero);
  assign cnt_val  = (state == IDLE) ? req_div : div_q;

  spi_halfper_cnt #(.DW(DW)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      sck        <= SCK_IDLE;
      ss         <= SS_IDLE;
      mosi       <= MOSI_IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      bcnt       <= '0;
      div_q      <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          tx_sh <= tx_aligned;
          rx_sh <= '0;
          bcnt  <= {1'b0, req_len_m1} + ONE;
          div_q <= req_div;
          ss    <= 1'b0;
          mosi  <= tx_aligned[MAX_LEN-1];
          state <= LOW;
        end
        LOW: if (zero) begin
          sck   <= 1'b1;
          state <= HIGH;
        end
        HIGH: if (zero) begin
          // miso is captured before mosi moves on this same edge
          sck   <= 1'b0;
          rx_sh <= {rx_sh[MAX_LEN-2:0], miso};
          bcnt  <= bcnt - ONE;
          if (bcnt == ONE) begin
            state <= TRAIL;
          end else begin
            mosi  <= tx_sh[MAX_LEN-2];
            tx_sh <= tx_sh << 1;
            state <= LOW;
          end
        end
        TRAIL: if (zero) begin
          ss         <= SS_IDLE;
          mosi       <= MOSI_IDLE;
          resp_rdata <= rx_sh;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;
  localparam int MAX_LEN = 32;
  localparam int LW = 5;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset, req_valid, req_ready, resp_valid, resp_ready;
  logic [MAX_LEN-1:0] req_wdata, resp_rdata;
  logic [LW-1:0] req_len_m1;
  logic [DW-1:0] req_div;
  logic sck, ss, mosi, miso;

  always #5 clock = ~clock;

  spi_master #(.MAX_LEN(MAX_LEN), .LW(LW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wdata(req_wdata),
    .req_len_m1(req_len_m1), .req_div(req_div),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // miso source: 0 loopback, 1 tied low, 2 bit-reversal slave, 3 random slave
  logic [1:0] mode;
  logic br_miso = 1'b1, rnd_miso = 1'b0;
  assign miso = (mode == 2'd0) ? mosi : (mode == 2'd1) ? 1'b0 :
                (mode == 2'd2) ? br_miso : rnd_miso;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    for (int i = 0; i < 8; i++) rev8[i] = b[7-i];
  endfunction

  // Byte slave: answers 0xFF for the first byte, then the bit-reversal of
  // each previously received byte. Samples mosi / drives miso on rising SCK.
  logic [7:0] br_in, br_out;
  int br_cnt;
  always @(posedge sck or posedge ss) begin
    if (ss) begin
      br_cnt = 0; br_in = 8'h00; br_out = 8'hFF;
    end else begin
      if (br_cnt % 8 == 0 && br_cnt > 0) br_out = rev8(br_in);
      br_miso <= br_out[7 - (br_cnt % 8)];
      br_in = {br_in[6:0], mosi};
      br_cnt++;
    end
  end

  // What the slave side observes on each rising SCK edge.
  logic mosi_seen[$];
  logic rbits[$];
  always @(posedge sck) begin
    logic b;
    mosi_seen.push_back(mosi);
    if (mode == 2'd3) begin
      b = 1'($urandom_range(0, 1));
      rbits.push_back(b);
      rnd_miso <= b;
    end
  end

  // Pin monitor sampled on the falling clock edge.
  int rises = 0, falls = 0, ss_low = 0;
  logic pv_sck = 1'b0, run_lvl = 1'b0;
  int run_len = 0;
  int runs[$];
  always @(negedge clock) begin
    if (sck === 1'b1 && !pv_sck) rises++;
    if (sck === 1'b0 && pv_sck) falls++;
    pv_sck = (sck === 1'b1);
    if (ss === 1'b0) begin
      ss_low++;
      if (sck == run_lvl) run_len++;
      else begin runs.push_back(run_len); run_lvl = sck; run_len = 1; end
    end else begin
      run_len = 0; run_lvl = 1'b0;
    end
  end

  task automatic launch(input logic [31:0] w, input int lm, input int d);
    @(negedge clock);
    req_wdata = w; req_len_m1 = LW'(lm); req_div = DW'(d); req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Cycles from the accept edge to resp_valid being visible.
  task automatic wait_resp(output int n);
    n = 0;
    do begin
      @(posedge clock); n++;
      @(negedge clock);
    end while (!resp_valid && n < 20000);
    if (!resp_valid) chk("resp_timeout", 64'(resp_valid), 64'd1);
  endtask

  task automatic take_resp();
    @(negedge clock); resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock); resp_ready = 1'b0;
    chk("ready_after_hs", 64'(req_ready), 64'd1);
    chk("valid_after_hs", 64'(resp_valid), 64'd0);
  endtask

  function automatic logic [31:0] lmask(input int len);
    logic [63:0] m;
    m = (64'd1 << len) - 64'd1;
    return m[31:0];
  endfunction

  // Runs one transfer and checks it against the reference: latency, SCK
  // count, bits presented on mosi, and returned data.
  task automatic xfer(input string tag, input logic [31:0] w, input int lm,
                      input int d, input logic [31:0] exp_rd, input logic use_rbits);
    int n, len, r0, mb, rb;
    logic [31:0] mw, rw;
    len = lm + 1;
    r0 = rises; mb = mosi_seen.size(); rb = rbits.size();
    launch(w, lm, d);
    wait_resp(n);
    chk({tag, "_lat"}, 64'(n), 64'((2*len+1)*(d+1)));
    chk({tag, "_rises"}, 64'(rises - r0), 64'(len));
    mw = '0; rw = '0;
    for (int i = 0; i < len; i++) begin
      if (mb + i < mosi_seen.size()) mw = {mw[30:0], mosi_seen[mb+i]};
      if (rb + i < rbits.size()) rw = {rw[30:0], rbits[rb+i]};
    end
    chk({tag, "_mosi"}, 64'(mw), 64'(w & lmask(len)));
    chk({tag, "_rdata"}, 64'(resp_rdata), 64'(use_rbits ? rw : exp_rd));
    take_resp();
  endtask

  initial begin
    int s0, r0, rb, n, f0;
    logic [31:0] w;
    int lm, d;
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_wdata = '0;
    req_len_m1 = '0; req_div = '0; mode = 2'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_rvalid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_pins", {61'd0, sck, ss, mosi}, 64'b011);
    reset = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // loopback, full word
    mode = 2'd0;
    xfer("loop32", 32'hDEADBEEF, 31, 0, 32'hDEADBEEF, 1'b0);

    // bit-reversal slave
    mode = 2'd2; s0 = ss_low;
    xfer("bitrev", 32'h0000A500, 15, 3, 32'h0000FFA5, 1'b0);
    chk("bitrev_sslow", 64'(ss_low - s0), 64'd132);

    // miso tied low, single bit
    mode = 2'd1;
    xfer("one_bit", 32'h1, 0, 0, 32'h0, 1'b0);

    // backpressure on the response
    mode = 2'd0;
    launch(32'h5A, 7, 0);
    wait_resp(n);
    r0 = rises;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      req_valid = (i % 3 == 0); req_wdata = $urandom; req_len_m1 = LW'(3);
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_rdata", 64'(resp_rdata), 64'h5A);
      chk("bp_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    chk("bp_no_sck", 64'(rises - r0), 64'd0);
    chk("bp_ss", 64'(ss), 64'd1);
    take_resp();
    repeat (20) @(negedge clock);
    chk("bp_not_buffered", 64'(rises - r0), 64'd0);

    // reset mid-transfer after 5 falling SCK edges
    f0 = falls;
    launch(32'h0000BEEF, 15, 1);
    n = 0;
    while (falls - f0 < 5 && n < 2000) begin @(negedge clock); n++; end
    chk("mid_rst_reached", 64'(falls - f0), 64'd5);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("mid_rst_pins", {61'd0, sck, ss, mosi}, 64'b011);
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_rvalid", 64'(resp_valid), 64'd0);
    chk("mid_rst_rdata", 64'(resp_rdata), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    xfer("after_rst", 32'h1234, 15, 0, 32'h1234, 1'b0);

    // divider extreme
    rb = runs.size();
    xfer("div255", 32'h2, 1, 255, 32'h2, 1'b0);
    chk("div255_runs", 64'(runs.size() - rb), 64'd4);
    for (int i = 0; i < 4; i++)
      if (rb + i < runs.size()) chk("div255_half", 64'(runs[rb+i]), 64'd256);

    // random: loopback and random-bit slave
    for (int t = 0; t < 30; t++) begin
      w = $urandom; lm = $urandom_range(0, 31); d = $urandom_range(0, 5);
      mode = (t % 2 == 1) ? 2'd3 : 2'd0;
      xfer("rand", w, lm, d, w & lmask(lm + 1), t % 2 == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
